// File: rtl/lock_pkg.sv
// lock_pkg: shared definitions for the lock attempt limiter.
//   state_t      - limiter states (ARMED, LOCKOUT)
//   FAIL_W       - fail counter / attempts_left width
//   SEC_W        - seconds down-counter width
//   tick_width() - prescaler width for a given ticks-per-second, minimum 1
package lock_pkg;

    typedef enum logic {
        ARMED   = 1'b0,
        LOCKOUT = 1'b1
    } state_t;

    localparam int FAIL_W = 4;
    localparam int SEC_W  = 7;

    function automatic int tick_width(input int ticks);
        return (ticks > 1) ? $clog2(ticks) : 1;
    endfunction

endpackage

// File: rtl/lockout_timer.sv
// lockout_timer: tick prescaler plus seconds down-counter for the lockout,
// with binary-to-BCD conversion of the remaining seconds.
//   i_clk      - system clock
//   i_rst_n    - asynchronous active-low reset
//   i_load     - load LOCKOUT_SECONDS and clear the prescaler
//   o_done     - one-cycle pulse on the wrap that takes seconds from 1 to 0
//   o_seconds  - seconds remaining (0 when idle)
//   o_bcd      - [7:4] tens, [3:0] units of o_seconds
module lockout_timer
    import lock_pkg::*;
#(
    parameter int TICKS_PER_SECOND = 50_000_000,
    parameter int LOCKOUT_SECONDS  = 30
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    output logic             o_done,
    output logic [SEC_W-1:0] o_seconds,
    output logic [7:0]       o_bcd
);

    localparam int TW = tick_width(TICKS_PER_SECOND);

    logic [TW-1:0]    r_tick;
    logic [SEC_W-1:0] r_seconds;
    logic             w_running;
    logic             w_wrap;
    logic [SEC_W-1:0] w_tens;
    logic [SEC_W-1:0] w_units;

    // The counter is idle whenever seconds is zero, so no separate enable.
    assign w_running = (r_seconds != '0);
    assign w_wrap    = w_running && (r_tick == TW'(TICKS_PER_SECOND - 1));
    assign o_done    = w_wrap && (r_seconds == SEC_W'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick    <= '0;
            r_seconds <= '0;
        end else if (i_load) begin
            r_tick    <= '0;
            r_seconds <= SEC_W'(LOCKOUT_SECONDS);
        end else if (w_wrap) begin
            r_tick    <= '0;
            r_seconds <= r_seconds - SEC_W'(1);
        end else if (w_running) begin
            r_tick    <= r_tick + TW'(1);
        end
    end

    // Seconds never exceed 99, so both digits fit in 4 bits.
    assign w_tens    = r_seconds / SEC_W'(10);
    assign w_units   = r_seconds % SEC_W'(10);
    assign o_seconds = r_seconds;
    assign o_bcd     = {w_tens[3:0], w_units[3:0]};

endmodule

// File: rtl/lock_attempt_limiter.sv
// lock_attempt_limiter: brute-force guard between the key filter and the
// lock FSM. Counts consecutive failed attempts and blocks keys for a timed
// lockout after MAX_ATTEMPTS failures.
//   i_clk             - system clock
//   i_rst_n           - asynchronous active-low reset
//   i_key_in[3:0]     - one-cycle key pulses from the key filter
//   i_error_flag      - FSM error level, rising edge = failed attempt
//   i_lock_flag       - FSM locked level, falling edge = successful unlock
//   o_key_out[3:0]    - registered, gated key pulses to the FSM
//   o_lockout         - high while locked out
//   o_attempts_left   - MAX_ATTEMPTS minus current fail count
//   o_countdown_bcd   - BCD seconds remaining, 0x00 when armed
//
// state   | meaning
// ARMED   | keys pass through, failed attempts are counted
// LOCKOUT | keys blocked, countdown running, edges ignored
module lock_attempt_limiter
    import lock_pkg::*;
#(
    parameter int MAX_ATTEMPTS     = 3,
    parameter int TICKS_PER_SECOND = 50_000_000,
    parameter int LOCKOUT_SECONDS  = 30
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [3:0]        i_key_in,
    input  logic              i_error_flag,
    input  logic              i_lock_flag,
    output logic [3:0]        o_key_out,
    output logic              o_lockout,
    output logic [FAIL_W-1:0] o_attempts_left,
    output logic [7:0]        o_countdown_bcd
);

    state_t            r_state;
    state_t            w_next_state;
    logic [FAIL_W-1:0] r_fail_count;
    logic [FAIL_W-1:0] w_fail_count_nxt;
    logic              r_error_prev;
    logic              r_lock_prev;
    logic [3:0]        r_key_out;
    logic              w_fail_edge;
    logic              w_unlock_edge;
    logic              w_enter;
    logic              w_done;
    logic [SEC_W-1:0]  w_seconds;
    logic [7:0]        w_bcd;

    assign w_fail_edge   = i_error_flag & ~r_error_prev;
    assign w_unlock_edge = ~i_lock_flag & r_lock_prev;

    lockout_timer #(
        .TICKS_PER_SECOND (TICKS_PER_SECOND),
        .LOCKOUT_SECONDS  (LOCKOUT_SECONDS)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (w_enter),
        .o_done    (w_done),
        .o_seconds (w_seconds),
        .o_bcd     (w_bcd)
    );

    always_comb begin
        w_next_state     = r_state;
        w_fail_count_nxt = r_fail_count;
        w_enter          = 1'b0;
        case (r_state)
            ARMED: begin
                // Unlock takes priority over a simultaneous failure.
                if (w_unlock_edge) begin
                    w_fail_count_nxt = '0;
                end else if (w_fail_edge) begin
                    if (r_fail_count == FAIL_W'(MAX_ATTEMPTS - 1)) begin
                        w_fail_count_nxt = '0;
                        w_enter          = 1'b1;
                        w_next_state     = LOCKOUT;
                    end else begin
                        w_fail_count_nxt = r_fail_count + FAIL_W'(1);
                    end
                end
            end
            LOCKOUT: begin
                if (w_done) begin
                    w_next_state = ARMED;
                end
            end
            default: w_next_state = ARMED;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ARMED;
            r_fail_count <= '0;
            r_error_prev <= 1'b0;
            r_lock_prev  <= 1'b0;
            r_key_out    <= '0;
        end else begin
            r_state      <= w_next_state;
            r_fail_count <= w_fail_count_nxt;
            r_error_prev <= i_error_flag;
            r_lock_prev  <= i_lock_flag;
            // The key sampled on the lockout-entry cycle is already blocked.
            r_key_out    <= (r_state == ARMED && !w_enter) ? i_key_in : 4'h0;
        end
    end

    assign o_key_out       = r_key_out;
    assign o_lockout       = (r_state == LOCKOUT);
    assign o_attempts_left = FAIL_W'(MAX_ATTEMPTS) - r_fail_count;
    assign o_countdown_bcd = (r_state == LOCKOUT) ? w_bcd : 8'h00;

endmodule

// File: tb/tb_lock_attempt_limiter.sv
module tb_lock_attempt_limiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_in;
    logic       error_flag;
    logic       lock_flag;
    logic [3:0] key_out;
    logic       lockout;
    logic [3:0] attempts_left;
    logic [7:0] countdown_bcd;

    int n_tests = 0;
    int n_fail  = 0;

    lock_attempt_limiter #(
        .MAX_ATTEMPTS     (3),
        .TICKS_PER_SECOND (4),
        .LOCKOUT_SECONDS  (12)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_key_in        (key_in),
        .i_error_flag    (error_flag),
        .i_lock_flag     (lock_flag),
        .o_key_out       (key_out),
        .o_lockout       (lockout),
        .o_attempts_left (attempts_left),
        .o_countdown_bcd (countdown_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_bcd;
        int         secs;

        rst_n      = 1'b0;
        key_in     = 4'h0;
        error_flag = 1'b0;
        lock_flag  = 1'b0;
        #12;
        check("rst_lockout",  {7'd0, lockout}, 8'h00);
        check("rst_attempts", {4'd0, attempts_left}, 8'h03);
        check("rst_bcd",      countdown_bcd, 8'h00);
        check("rst_keyout",   {4'd0, key_out}, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();

        // Key pass-through, one cycle latency, not stretched
        key_in = 4'b0010;
        tick();
        key_in = 4'h0;
        check("key_pass",       {4'd0, key_out}, 8'h02);
        check("key_pass_att",   {4'd0, attempts_left}, 8'h03);
        check("key_pass_bcd",   countdown_bcd, 8'h00);
        tick();
        check("key_no_stretch", {4'd0, key_out}, 8'h00);

        // Two failures then unlock
        error_flag = 1'b1; tick();
        check("fail1_att", {4'd0, attempts_left}, 8'h02);
        error_flag = 1'b0; tick();
        error_flag = 1'b1; tick();
        check("fail2_att",  {4'd0, attempts_left}, 8'h01);
        check("fail2_lock", {7'd0, lockout}, 8'h00);
        error_flag = 1'b0; tick();
        lock_flag = 1'b1; tick();
        lock_flag = 1'b0; tick();
        check("unlock_att", {4'd0, attempts_left}, 8'h03);

        // Back to one attempt left, then third failure with a key on the entry cycle
        error_flag = 1'b1; tick();
        error_flag = 1'b0; tick();
        error_flag = 1'b1; tick();
        error_flag = 1'b0; tick();
        check("pre_lock_att", {4'd0, attempts_left}, 8'h01);
        error_flag = 1'b1;
        key_in     = 4'hF;
        tick();
        check("entry_lock",   {7'd0, lockout}, 8'h01);
        check("entry_bcd",    countdown_bcd, 8'h12);
        check("entry_keyout", {4'd0, key_out}, 8'h00);
        check("entry_att",    {4'd0, attempts_left}, 8'h03);

        // 48 lockout cycles; edges injected midway must be ignored
        for (int k = 1; k <= 48; k++) begin
            if (k == 20) error_flag = 1'b0;
            if (k == 22) error_flag = 1'b1;
            if (k == 24) lock_flag  = 1'b1;
            if (k == 26) lock_flag  = 1'b0;
            tick();
            check("lo_keyout", {4'd0, key_out}, 8'h00);
            check("lo_att",    {4'd0, attempts_left}, 8'h03);
            if (k < 48) begin
                secs    = 12 - k / 4;
                exp_bcd = {4'(secs / 10), 4'(secs % 10)};
                check("lo_active", {7'd0, lockout}, 8'h01);
                check("lo_bcd",    countdown_bcd, exp_bcd);
            end
            if (k == 4)  check("lo_bcd_11", countdown_bcd, 8'h11);
            if (k == 12) check("lo_bcd_09", countdown_bcd, 8'h09);
        end
        check("exit_lock", {7'd0, lockout}, 8'h00);
        check("exit_bcd",  countdown_bcd, 8'h00);
        check("exit_att",  {4'd0, attempts_left}, 8'h03);

        // First ARMED cycle key passes; held error_flag gives no new failure
        key_in = 4'b0100;
        tick();
        key_in = 4'h0;
        check("post_key", {4'd0, key_out}, 8'h04);
        check("post_att", {4'd0, attempts_left}, 8'h03);
        tick();
        check("held_err_att", {4'd0, attempts_left}, 8'h03);

        // Simultaneous failure and unlock with one attempt left
        error_flag = 1'b0; tick();
        error_flag = 1'b1; tick();
        error_flag = 1'b0; tick();
        error_flag = 1'b1; tick();
        error_flag = 1'b0;
        lock_flag  = 1'b1; tick();
        check("sim_pre_att", {4'd0, attempts_left}, 8'h01);
        error_flag = 1'b1;
        lock_flag  = 1'b0;
        tick();
        check("sim_att",  {4'd0, attempts_left}, 8'h03);
        check("sim_lock", {7'd0, lockout}, 8'h00);
        tick();
        check("sim_lock2", {7'd0, lockout}, 8'h00);

        // Lockout again, then asynchronous reset at countdown 0x07
        error_flag = 1'b0; tick();
        error_flag = 1'b1; tick();
        error_flag = 1'b0; tick();
        error_flag = 1'b1; tick();
        error_flag = 1'b0; tick();
        error_flag = 1'b1; tick();
        check("relock", {7'd0, lockout}, 8'h01);
        for (int k = 0; k < 20; k++) tick();
        check("rl_bcd_07", countdown_bcd, 8'h07);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_lock", {7'd0, lockout}, 8'h00);
        check("arst_bcd",  countdown_bcd, 8'h00);
        check("arst_att",  {4'd0, attempts_left}, 8'h03);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
